bank_rf_wb_queue: RTL and testbench

Writeback staging queue that drives the two write ports of the banked 32-entry register file (even bank and odd bank, split on address bit 0). It accepts up to two writeback requests per cycle from the commit lanes, sorts them into one FIFO per bank, and issues at most one write per bank per cycle. The register file therefore never sees a bank conflict. The block also exports a per-register busy mask so issue logic can stall reads of registers whose writes are still queued.

---
 rtl/bank_rf_wb_queue.sv | 194 +++++++++++++++++++
 tb/tb_bank_rf_wb_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_rf_wb_queue.sv
// bank_rf_wb_queue
//
// Writeback staging queue in front of a banked 32-entry register file.
// Two commit lanes present up to two writes per cycle. Each write is sorted into
// one of two FIFOs by its destination register's bit 0 (even bank and odd bank).
// Each FIFO issues its head to its own regfile write port every cycle it is
// non-empty, so neither port ever sees two writes in one cycle.
// Writes to r0 are accepted and dropped.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in0_valid_i/addr_i/data_i   lane 0 (older) write request
//   in0_ready_o                 lane 0 accepted when valid & ready
//   in1_valid_i/addr_i/data_i   lane 1 (younger) write request
//   in1_ready_o                 lane 1 accepted when valid & ready
//   we0_o/wa0_o/wd0_o           even-bank write port (wa0_o[0] == 0)
//   we1_o/wa1_o/wd1_o           odd-bank write port  (wa1_o[0] == 1)
//   busy_o                      bit r set while a write to r is queued
//   empty_o                     both FIFOs empty

module bank_rf_wb_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in0_valid_i,
    input  logic [4:0]       in0_addr_i,
    input  logic [WIDTH-1:0] in0_data_i,
    output logic             in0_ready_o,

    input  logic             in1_valid_i,
    input  logic [4:0]       in1_addr_i,
    input  logic [WIDTH-1:0] in1_data_i,
    output logic             in1_ready_o,

    output logic             we0_o,
    output logic [4:0]       wa0_o,
    output logic [WIDTH-1:0] wd0_o,

    output logic             we1_o,
    output logic [4:0]       wa1_o,
    output logic [WIDTH-1:0] wd1_o,

    output logic [31:0]      busy_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    // Count thresholds for one and two free slots.
    localparam logic [CntW-1:0] CntOneFree = CntW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntTwoFree = CntW'(DEPTH - 2);

    // Per-bank FIFO state; index 0 is the even bank, index 1 the odd bank.
    logic [CntW-1:0]  cnt_q  [2];
    logic [CntW-1:0]  cnt_d  [2];
    logic [PtrW-1:0]  rptr_q [2];
    logic [PtrW-1:0]  rptr_d [2];
    logic [PtrW-1:0]  wptr_q [2];
    logic [PtrW-1:0]  wptr_d [2];

    // Only addr[4:1] is stored; bit 0 is implied by the bank.
    logic [3:0]       addr_mem_q [2][DEPTH];
    logic [WIDTH-1:0] data_mem_q [2][DEPTH];

    logic             in0_nz;
    logic             in1_nz;
    logic             bank0;
    logic             bank1;
    logic             same_bank;
    logic             in0_rdy;
    logic             in1_rdy;
    logic             in0_push;
    logic             in1_push;
    logic [1:0]       push0_b;
    logic [1:0]       push1_b;
    logic [1:0]       pop_b;
    logic [PtrW-1:0]  wr1_idx [2];

    // Acceptance. Readiness uses registered counts only; a head popping this
    // cycle does not free a slot until the next cycle.
    always_comb begin
        in0_nz    = |in0_addr_i;
        in1_nz    = |in1_addr_i;
        bank0     = in0_addr_i[0];
        bank1     = in1_addr_i[0];
        // Lane 0 takes a slot in lane 1's bank, so lane 1 needs two free.
        same_bank = in0_valid_i && in0_nz && (bank0 == bank1);

        in0_rdy = !in0_nz || (cnt_q[bank0] <= CntOneFree);

        // Lane 1 may only be accepted alongside (or without) lane 0, never
        // ahead of it.
        in1_rdy = (!in0_valid_i || in0_rdy) &&
                  (!in1_nz ||
                   (same_bank ? (cnt_q[bank1] <= CntTwoFree)
                              : (cnt_q[bank1] <= CntOneFree)));

        // r0 writes handshake but never occupy a slot.
        in0_push = in0_valid_i && in0_rdy && in0_nz;
        in1_push = in1_valid_i && in1_rdy && in1_nz;
    end

    assign in0_ready_o = in0_rdy;
    assign in1_ready_o = in1_rdy;

    // Per-bank pointer and count update.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            push0_b[b] = in0_push && (bank0 == 1'(b));
            push1_b[b] = in1_push && (bank1 == 1'(b));
            pop_b[b]   = (cnt_q[b] != '0);

            // Lane 1 lands behind lane 0 when both hit the same bank.
            wr1_idx[b] = push0_b[b] ? (wptr_q[b] + PtrW'(1)) : wptr_q[b];

            wptr_d[b] = wptr_q[b] + PtrW'(push0_b[b]) + PtrW'(push1_b[b]);
            rptr_d[b] = rptr_q[b] + PtrW'(pop_b[b]);
            cnt_d[b]  = cnt_q[b] + CntW'(push0_b[b]) + CntW'(push1_b[b])
                      - CntW'(pop_b[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                cnt_q[b]  <= '0;
                rptr_q[b] <= '0;
                wptr_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                cnt_q[b]  <= cnt_d[b];
                rptr_q[b] <= rptr_d[b];
                wptr_q[b] <= wptr_d[b];
            end
        end
    end

    // Storage is not reset: entries are qualified by the counts, and the
    // write ports are gated to zero while a bank is empty.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (push0_b[b]) begin
                addr_mem_q[b][wptr_q[b]] <= in0_addr_i[4:1];
                data_mem_q[b][wptr_q[b]] <= in0_data_i;
            end
            if (push1_b[b]) begin
                addr_mem_q[b][wr1_idx[b]] <= in1_addr_i[4:1];
                data_mem_q[b][wr1_idx[b]] <= in1_data_i;
            end
        end
    end

    // Issue: the head goes out every cycle its bank is non-empty and pops at
    // the same edge.
    always_comb begin
        we0_o = pop_b[0];
        wa0_o = '0;
        wd0_o = '0;
        if (pop_b[0]) begin
            wa0_o = {addr_mem_q[0][rptr_q[0]], 1'b0};
            wd0_o = data_mem_q[0][rptr_q[0]];
        end

        we1_o = pop_b[1];
        wa1_o = '0;
        wd1_o = '0;
        if (pop_b[1]) begin
            wa1_o = {addr_mem_q[1][rptr_q[1]], 1'b1};
            wd1_o = data_mem_q[1][rptr_q[1]];
        end
    end

    // Busy mask: a slot is live when its distance from the read pointer,
    // taken modulo DEPTH, is below the count.
    always_comb begin
        busy_o = '0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if ({1'b0, PtrW'(PtrW'(i) - rptr_q[b])} < cnt_q[b]) begin
                    busy_o[{addr_mem_q[b][i], 1'(b)}] = 1'b1;
                end
            end
        end
        busy_o[0] = 1'b0;
    end

    assign empty_o = (cnt_q[0] == '0) && (cnt_q[1] == '0);

endmodule

// File: tb/tb_bank_rf_wb_queue.sv
// Directed self-checking bench for bank_rf_wb_queue (WIDTH=32, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_bank_rf_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid_i;
    logic [4:0]  in0_addr_i;
    logic [31:0] in0_data_i;
    logic        in0_ready_o;
    logic        in1_valid_i;
    logic [4:0]  in1_addr_i;
    logic [31:0] in1_data_i;
    logic        in1_ready_o;
    logic        we0_o;
    logic [4:0]  wa0_o;
    logic [31:0] wd0_o;
    logic        we1_o;
    logic [4:0]  wa1_o;
    logic [31:0] wd1_o;
    logic [31:0] busy_o;
    logic        empty_o;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int wr_snap;
    logic [31:0] last_r4;

    bank_rf_wb_queue #(
        .WIDTH(32),
        .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_valid_i(in0_valid_i),
        .in0_addr_i (in0_addr_i),
        .in0_data_i (in0_data_i),
        .in0_ready_o(in0_ready_o),
        .in1_valid_i(in1_valid_i),
        .in1_addr_i (in1_addr_i),
        .in1_data_i (in1_data_i),
        .in1_ready_o(in1_ready_o),
        .we0_o      (we0_o),
        .wa0_o      (wa0_o),
        .wd0_o      (wd0_o),
        .we1_o      (we1_o),
        .wa1_o      (wa1_o),
        .wd1_o      (wd1_o),
        .busy_o     (busy_o),
        .empty_o    (empty_o)
    );

    always #5 clk = ~clk;

    // Regfile-side observers.
    always @(posedge clk) begin
        if (we0_o || we1_o) wr_cnt <= wr_cnt + 1;
        if (we0_o && wa0_o == 5'd4) last_r4 <= wd0_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        in0_valid_i = v0;
        in0_addr_i  = a0;
        in0_data_i  = d0;
        in1_valid_i = v1;
        in1_addr_i  = a1;
        in1_data_i  = d1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_we0", 32'(we0_o), 32'd0);
        check("rst_we1", 32'(we1_o), 32'd0);
        check("rst_wa0", 32'(wa0_o), 32'd0);
        check("rst_wd1", wd1_o, 32'd0);
        check("rst_busy", busy_o, 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_rdy0", 32'(in0_ready_o), 32'd1);
        check("rst_rdy1", 32'(in1_ready_o), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single odd write r5 = 0xA5
        drive(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'd0);
        #1;
        check("t1_rdy0", 32'(in0_ready_o), 32'd1);
        tick();
        idle();
        check("t1_we1", 32'(we1_o), 32'd1);
        check("t1_wa1", 32'(wa1_o), 32'd5);
        check("t1_wd1", wd1_o, 32'hA5);
        check("t1_we0", 32'(we0_o), 32'd0);
        check("t1_busy", busy_o, 32'h0000_0020);
        check("t1_empty", 32'(empty_o), 32'd0);
        tick();
        check("t1_busy_clr", busy_o, 32'd0);
        check("t1_empty_set", 32'(empty_o), 32'd1);
        check("t1_we1_off", 32'(we1_o), 32'd0);

        // Two banks in one cycle: r2 (even) and r3 (odd)
        drive(1'b1, 5'd2, 32'h11, 1'b1, 5'd3, 32'h22);
        #1;
        check("t2_rdy0", 32'(in0_ready_o), 32'd1);
        check("t2_rdy1", 32'(in1_ready_o), 32'd1);
        tick();
        idle();
        check("t2_we0", 32'(we0_o), 32'd1);
        check("t2_wa0", 32'(wa0_o), 32'd2);
        check("t2_wd0", wd0_o, 32'h11);
        check("t2_we1", 32'(we1_o), 32'd1);
        check("t2_wa1", 32'(wa1_o), 32'd3);
        check("t2_wd1", wd1_o, 32'h22);
        check("t2_busy", busy_o, 32'h0000_000C);
        tick();
        check("t2_empty", 32'(empty_o), 32'd1);

        // Same register on both lanes: lane 1's data lands last
        drive(1'b1, 5'd4, 32'd1, 1'b1, 5'd4, 32'd2);
        #1;
        check("t3_rdy1", 32'(in1_ready_o), 32'd1);
        tick();
        idle();
        check("t3_wa0_a", 32'(wa0_o), 32'd4);
        check("t3_wd0_a", wd0_o, 32'd1);
        check("t3_busy_a", busy_o, 32'h0000_0010);
        tick();
        check("t3_we0_b", 32'(we0_o), 32'd1);
        check("t3_wa0_b", 32'(wa0_o), 32'd4);
        check("t3_wd0_b", wd0_o, 32'd2);
        check("t3_busy_b", busy_o, 32'h0000_0010);
        tick();
        check("t3_busy_clr", busy_o, 32'd0);
        check("t3_empty", 32'(empty_o), 32'd1);
        check("t3_final_r4", last_r4, 32'd2);

        // Even-bank stream; the head pops every cycle, so the count tops out
        // at DEPTH-1 and lane 1 stalls there when lane 0 shares the bank.
        drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd8, 32'h80);
        #1;
        check("t4a_rdy1", 32'(in1_ready_o), 32'd1);
        tick();                                   // fifo0 = [6,8]
        check("t4a_wa0", 32'(wa0_o), 32'd6);
        check("t4a_busy", busy_o, 32'h0000_0140);
        drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd12, 32'hC0);
        #1;
        check("t4b_rdy0", 32'(in0_ready_o), 32'd1);
        check("t4b_rdy1", 32'(in1_ready_o), 32'd1);
        tick();                                   // fifo0 = [8,10,12]
        check("t4b_wa0", 32'(wa0_o), 32'd8);
        check("t4b_busy", busy_o, 32'h0000_1500);
        // Probe: with lane 0 odd, lane 1 only needs one free slot.
        drive(1'b1, 5'd15, 32'hF0, 1'b1, 5'd16, 32'h100);
        #1;
        check("t4c_rdy1_odd0", 32'(in1_ready_o), 32'd1);
        drive(1'b1, 5'd14, 32'hE0, 1'b1, 5'd16, 32'h100);
        #1;
        check("t4c_rdy0", 32'(in0_ready_o), 32'd1);
        check("t4c_rdy1", 32'(in1_ready_o), 32'd0);
        tick();                                   // fifo0 = [10,12,14]
        idle();
        check("t4c_wa0", 32'(wa0_o), 32'd10);
        check("t4c_busy", busy_o, 32'h0000_5400);
        tick();
        check("t4d_wa0", 32'(wa0_o), 32'd12);
        tick();
        check("t4e_wa0", 32'(wa0_o), 32'd14);
        check("t4e_wd0", wd0_o, 32'hE0);
        tick();
        check("t4f_empty", 32'(empty_o), 32'd1);

        // r0 on lane 0 is dropped; r6 on lane 1 is issued
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd6, 32'h66);
        #1;
        check("t5_rdy0", 32'(in0_ready_o), 32'd1);
        check("t5_rdy1", 32'(in1_ready_o), 32'd1);
        tick();
        idle();
        check("t5_we0", 32'(we0_o), 32'd1);
        check("t5_wa0", 32'(wa0_o), 32'd6);
        check("t5_wd0", wd0_o, 32'h66);
        check("t5_we1", 32'(we1_o), 32'd0);
        check("t5_busy", busy_o, 32'h0000_0040);
        tick();
        check("t5_empty", 32'(empty_o), 32'd1);

        // Fill both banks, then reset mid-operation
        drive(1'b1, 5'd20, 32'd20, 1'b1, 5'd22, 32'd22);
        tick();                                   // fifo0 = [20,22]
        drive(1'b1, 5'd21, 32'd21, 1'b1, 5'd23, 32'd23);
        tick();                                   // fifo0 = [22], fifo1 = [21,23]
        drive(1'b1, 5'd24, 32'd24, 1'b1, 5'd26, 32'd26);
        tick();                                   // fifo0 = [24,26], fifo1 = [23]
        idle();
        check("t6_busy_full", busy_o, 32'h0580_0000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wr_snap = wr_cnt;
        check("t6_we0", 32'(we0_o), 32'd0);
        check("t6_we1", 32'(we1_o), 32'd0);
        check("t6_busy", busy_o, 32'd0);
        check("t6_empty", 32'(empty_o), 32'd1);
        tick();
        tick();
        tick();
        check("t6_no_writes", 32'(wr_cnt), 32'(wr_snap));
        check("t6_empty_hold", 32'(empty_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
